// File: rtl/reg_wb_arb_if.sv
// Bundle of the write-back arbiter's bus signals: ALU result, long-latency result,
// issue-side scoreboard query and the registered register-file write port.
interface reg_wb_arb_if;
    logic        alu_valid;
    logic [4:0]  alu_num;
    logic [31:0] alu_data;
    logic        wb_stall;

    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_num;
    logic [31:0] lsu_data;

    logic        issue_valid;
    logic [4:0]  issue_num;
    logic [4:0]  rd1;
    logic [4:0]  rd2;
    logic        busy1;
    logic        busy2;

    logic        reg_wr;
    logic [4:0]  wr_num;
    logic [31:0] wr_data;

    modport master (
        output alu_valid, alu_num, alu_data,
        output lsu_valid, lsu_num, lsu_data,
        output issue_valid, issue_num, rd1, rd2,
        input  wb_stall, lsu_ready, busy1, busy2,
        input  reg_wr, wr_num, wr_data
    );

    modport slave (
        input  alu_valid, alu_num, alu_data,
        input  lsu_valid, lsu_num, lsu_data,
        input  issue_valid, issue_num, rd1, rd2,
        output wb_stall, lsu_ready, busy1, busy2,
        output reg_wr, wr_num, wr_data
    );
endinterface

// File: rtl/reg_wb_arb.sv
// Write-back arbiter for the general register file: merges ALU results with buffered
// long-latency results and keeps a pending-write scoreboard for RAW stalls.
module reg_wb_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    reg_wb_arb_if.slave  bus
);
    localparam int SW = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [4:0]    fnum_q  [2];
    logic [4:0]    fnum_d  [2];
    logic [31:0]   fdata_q [2];
    logic [31:0]   fdata_d [2];
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0]   pending_q, pending_d;
    logic          reg_wr_q, reg_wr_d;
    logic [4:0]    wr_num_q, wr_num_d;
    logic [31:0]   wr_data_q, wr_data_d;
    logic          src_lsu_q, src_lsu_d;

    logic fifo_nonempty;
    logic lsu_ready_c;
    logic push;
    logic force_pop;
    logic pop;
    logic bypass;
    logic enqueue;

    // An LSU result arriving into an empty buffer with no ALU competition goes
    // straight to the write port so the load costs only one cycle.
    always_comb begin
        fifo_nonempty = (count_q != 2'd0);
        lsu_ready_c   = !rst && (count_q != 2'd2);
        push          = bus.lsu_valid && lsu_ready_c;
        force_pop     = fifo_nonempty && (starve_q >= STARVE_MAX);
        pop           = force_pop || (fifo_nonempty && !bus.alu_valid);
        bypass        = push && !fifo_nonempty && !bus.alu_valid;
        enqueue       = push && !bypass;
    end

    always_comb begin
        reg_wr_d  = 1'b0;
        wr_num_d  = wr_num_q;
        wr_data_d = wr_data_q;
        src_lsu_d = 1'b0;
        if (pop) begin
            reg_wr_d  = (fnum_q[rd_ptr_q] != 5'd0);
            wr_num_d  = fnum_q[rd_ptr_q];
            wr_data_d = fdata_q[rd_ptr_q];
            src_lsu_d = 1'b1;
        end else if (bus.alu_valid) begin
            reg_wr_d  = (bus.alu_num != 5'd0);
            wr_num_d  = bus.alu_num;
            wr_data_d = bus.alu_data;
        end else if (bypass) begin
            reg_wr_d  = (bus.lsu_num != 5'd0);
            wr_num_d  = bus.lsu_num;
            wr_data_d = bus.lsu_data;
            src_lsu_d = 1'b1;
        end
    end

    always_comb begin
        fnum_d   = fnum_q;
        fdata_d  = fdata_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (enqueue) begin
            fnum_d[wr_ptr_q]  = bus.lsu_num;
            fdata_d[wr_ptr_q] = bus.lsu_data;
            wr_ptr_d          = !wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        count_d = count_q + 2'(enqueue) - 2'(pop);
    end

    always_comb begin
        starve_d = starve_q;
        if (pop || !fifo_nonempty) begin
            starve_d = '0;
        end else if (starve_q < STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Clear happens on the edge the register file captures the data; a fresh issue
    // to the same register in that cycle must stay pending.
    always_comb begin
        pending_d = pending_q;
        if (reg_wr_q && src_lsu_q) begin
            pending_d[wr_num_q] = 1'b0;
        end
        if (bus.issue_valid) begin
            pending_d[bus.issue_num] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            starve_q  <= '0;
            pending_q <= 32'd0;
            reg_wr_q  <= 1'b0;
            wr_num_q  <= 5'd0;
            wr_data_q <= 32'd0;
            src_lsu_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            pending_q <= pending_d;
            reg_wr_q  <= reg_wr_d;
            wr_num_q  <= wr_num_d;
            wr_data_q <= wr_data_d;
            src_lsu_q <= src_lsu_d;
        end
    end

    always_ff @(posedge clk) begin
        fnum_q  <= fnum_d;
        fdata_q <= fdata_d;
    end

    assign bus.lsu_ready = lsu_ready_c;
    assign bus.wb_stall  = !rst && force_pop && bus.alu_valid;
    assign bus.busy1     = !rst && pending_q[bus.rd1];
    assign bus.busy2     = !rst && pending_q[bus.rd2];
    assign bus.reg_wr    = reg_wr_q;
    assign bus.wr_num    = wr_num_q;
    assign bus.wr_data   = wr_data_q;
endmodule

// File: tb/tb_reg_wb_arb.sv
// Self-checking bench for reg_wb_arb: a queue-based reference model checked every cycle,
// a table of single-cycle vectors, directed multi-cycle sequences and a random phase.
module tb_reg_wb_arb;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_wb_arb_if bus();
    reg_wb_arb #(.STARVE_LIMIT(LIMIT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  num;
        logic [31:0] data;
    } ent_t;

    // Reference model: buffered results, pending set, age of the head entry, write port
    ent_t        mq[$];
    bit   [31:0] m_pend;
    int          m_age;
    bit          m_wr;
    bit   [4:0]  m_num;
    bit   [31:0] m_data;
    bit          m_src;
    bit          last_stall;
    logic [4:0]  wlog[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic m_write(input bit [4:0] num, input bit [31:0] data, input bit src);
        m_wr   = (num != 5'd0);
        m_num  = num;
        m_data = data;
        m_src  = src;
    endtask

    task automatic model_update();
        int    had;
        bit    push, popped;
        bit [31:0] npend;
        ent_t  e;
        if (rst) begin
            mq.delete();
            m_pend = '0; m_age = 0; m_wr = 0; m_num = 0; m_data = 0; m_src = 0;
            return;
        end
        had    = mq.size();
        push   = bus.lsu_valid && (had < 2);
        popped = 0;
        npend  = m_pend;
        if (m_wr && m_src) npend[m_num] = 1'b0;
        if (bus.issue_valid && bus.issue_num != 5'd0) npend[bus.issue_num] = 1'b1;
        if (had > 0 && (m_age >= LIMIT || !bus.alu_valid)) begin
            e = mq.pop_front();
            m_write(e.num, e.data, 1'b1);
            popped = 1;
        end else if (bus.alu_valid) begin
            m_write(bus.alu_num, bus.alu_data, 1'b0);
        end else if (push) begin
            m_write(bus.lsu_num, bus.lsu_data, 1'b1);
            push = 0;
        end else begin
            m_wr = 0;
        end
        if (popped || had == 0) m_age = 0;
        else if (m_age < LIMIT) m_age++;
        if (push) mq.push_back('{num: bus.lsu_num, data: bus.lsu_data});
        m_pend = npend;
    endtask

    // Called at a falling edge with inputs applied; returns at the next falling edge.
    task automatic step();
        bit exp_ready, exp_stall;
        #1;
        exp_ready = !rst && mq.size() < 2;
        exp_stall = !rst && mq.size() > 0 && m_age >= LIMIT && bus.alu_valid;
        chk("lsu_ready", {31'd0, bus.lsu_ready}, {31'd0, exp_ready});
        chk("wb_stall", {31'd0, bus.wb_stall}, {31'd0, exp_stall});
        chk("busy1", {31'd0, bus.busy1}, {31'd0, (!rst && bus.rd1 != 0) ? m_pend[bus.rd1] : 1'b0});
        chk("busy2", {31'd0, bus.busy2}, {31'd0, (!rst && bus.rd2 != 0) ? m_pend[bus.rd2] : 1'b0});
        last_stall = bus.wb_stall;
        model_update();
        @(posedge clk);
        #1;
        chk("reg_wr", {31'd0, bus.reg_wr}, {31'd0, m_wr});
        if (m_wr) begin
            chk("wr_num", {27'd0, bus.wr_num}, {27'd0, m_num});
            chk("wr_data", bus.wr_data, m_data);
        end
        if (bus.reg_wr) wlog.push_back(bus.wr_num);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.alu_valid = 0; bus.alu_num = 0; bus.alu_data = 0;
        bus.lsu_valid = 0; bus.lsu_num = 0; bus.lsu_data = 0;
        bus.issue_valid = 0; bus.issue_num = 0;
        bus.rd1 = 0; bus.rd2 = 0;
    endtask

    typedef struct {
        bit        av;
        bit [4:0]  an;
        bit [31:0] ad;
        bit        lv;
        bit [4:0]  ln;
        bit [31:0] ld;
        bit        e_wr;
        bit [4:0]  e_num;
        bit [31:0] e_data;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{1, 5'd5,  32'hDEADBEEF, 0, 5'd0, 32'h0,    1, 5'd5,  32'hDEADBEEF};
        vecs[1] = '{1, 5'd0,  32'h00000055, 0, 5'd0, 32'h0,    0, 5'd0,  32'h0};
        vecs[2] = '{0, 5'd0,  32'h0,        1, 5'd3, 32'hA5A5, 1, 5'd3,  32'hA5A5};
        vecs[3] = '{1, 5'd4,  32'h44,       1, 5'd6, 32'h66,   1, 5'd4,  32'h44};
        vecs[4] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,    1, 5'd6,  32'h66};
        vecs[5] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,    0, 5'd0,  32'h0};
        vecs[6] = '{0, 5'd0,  32'h0,        1, 5'd0, 32'h99,   0, 5'd0,  32'h0};
        vecs[7] = '{1, 5'd31, 32'hFFFFFFFF, 0, 5'd0, 32'h0,    1, 5'd31, 32'hFFFFFFFF};

        idle();
        rst = 1;
        @(negedge clk);
        step();
        step();
        chk("rst_reg_wr", {31'd0, bus.reg_wr}, 32'd0);
        chk("rst_wr_num", {27'd0, bus.wr_num}, 32'd0);
        chk("rst_wr_data", bus.wr_data, 32'd0);
        chk("rst_lsu_ready", {31'd0, bus.lsu_ready}, 32'd0);
        rst = 0;
        #1;
        chk("post_rst_lsu_ready", {31'd0, bus.lsu_ready}, 32'd1);
        @(negedge clk);

        // Single-cycle vectors
        for (int i = 0; i < 8; i++) begin
            idle();
            bus.alu_valid = vecs[i].av; bus.alu_num = vecs[i].an; bus.alu_data = vecs[i].ad;
            bus.lsu_valid = vecs[i].lv; bus.lsu_num = vecs[i].ln; bus.lsu_data = vecs[i].ld;
            step();
            chk($sformatf("vec%0d_reg_wr", i), {31'd0, bus.reg_wr}, {31'd0, vecs[i].e_wr});
            if (vecs[i].e_wr) begin
                chk($sformatf("vec%0d_wr_num", i), {27'd0, bus.wr_num}, {27'd0, vecs[i].e_num});
                chk($sformatf("vec%0d_wr_data", i), bus.wr_data, vecs[i].e_data);
            end
        end

        // Scoreboard: issue r7, deliver 0x1234 four cycles later
        idle(); bus.issue_valid = 1; bus.issue_num = 7; bus.rd1 = 7;
        step();
        idle(); bus.rd1 = 7;
        #1 chk("sb_busy_set", {31'd0, bus.busy1}, 32'd1);
        step();
        step();
        step();
        bus.lsu_valid = 1; bus.lsu_num = 7; bus.lsu_data = 32'h1234;
        step();
        chk("sb_wr", {31'd0, bus.reg_wr}, 32'd1);
        chk("sb_wr_num", {27'd0, bus.wr_num}, 32'd7);
        chk("sb_wr_data", bus.wr_data, 32'h1234);
        idle(); bus.rd1 = 7;
        #1 chk("sb_busy_hold", {31'd0, bus.busy1}, 32'd1);
        step();
        #1 chk("sb_busy_clear", {31'd0, bus.busy1}, 32'd0);
        bus.rd1 = 0;
        #1 chk("sb_busy_r0", {31'd0, bus.busy1}, 32'd0);
        @(negedge clk);

        // Set/clear collision on r9
        idle(); bus.issue_valid = 1; bus.issue_num = 9;
        step();
        idle(); bus.lsu_valid = 1; bus.lsu_num = 9; bus.lsu_data = 32'h9999;
        step();
        idle(); bus.issue_valid = 1; bus.issue_num = 9;
        step();
        idle(); bus.rd1 = 9;
        #1 chk("collide_busy", {31'd0, bus.busy1}, 32'd1);
        bus.lsu_valid = 1; bus.lsu_num = 9; bus.lsu_data = 32'h9A9A;
        step();
        idle(); bus.rd1 = 9;
        step();
        #1 chk("collide_cleared", {31'd0, bus.busy1}, 32'd0);
        @(negedge clk);

        // Fill and backpressure under continuous ALU traffic
        wlog.delete();
        idle(); bus.alu_valid = 1; bus.alu_num = 10; bus.alu_data = 32'hA0;
        bus.lsu_valid = 1; bus.lsu_num = 1; bus.lsu_data = 32'h11;
        step();
        bus.lsu_num = 2; bus.lsu_data = 32'h22;
        step();
        bus.lsu_num = 3; bus.lsu_data = 32'h33;
        #1 chk("fill_ready_low", {31'd0, bus.lsu_ready}, 32'd0);
        begin
            bit acc = 0;
            for (int n = 0; n < 20 && !acc; n++) begin
                #1 acc = bus.lsu_ready;
                step();
            end
            chk("fill_third_accepted", {31'd0, acc}, 32'd1);
        end
        idle();
        for (int n = 0; n < 4; n++) step();
        begin
            logic [4:0] got[$];
            foreach (wlog[k]) if (wlog[k] inside {5'd1, 5'd2, 5'd3}) got.push_back(wlog[k]);
            chk("fill_count", got.size(), 3);
            if (got.size() == 3) begin
                chk("fill_order0", {27'd0, got[0]}, 32'd1);
                chk("fill_order1", {27'd0, got[1]}, 32'd2);
                chk("fill_order2", {27'd0, got[2]}, 32'd3);
            end
        end

        // Starvation: one buffered entry behind continuous ALU traffic
        begin
            int   seen_at = -1;
            int   stalls = 0;
            logic [31:0] held = 0;
            bit   check_held = 0;
            idle(); bus.alu_valid = 1; bus.alu_num = 11; bus.alu_data = 32'h100;
            bus.lsu_valid = 1; bus.lsu_num = 12; bus.lsu_data = 32'hC0C0;
            for (int n = 1; n <= 10; n++) begin
                step();
                bus.lsu_valid = 0;
                if (check_held) begin
                    chk("starve_held_num", {27'd0, bus.wr_num}, 32'd11);
                    chk("starve_held_data", bus.wr_data, held);
                    check_held = 0;
                end
                if (bus.reg_wr && bus.wr_num == 5'd12 && seen_at < 0) seen_at = n;
                if (last_stall) begin
                    stalls++;
                    held = bus.alu_data;
                    check_held = 1;
                end else begin
                    bus.alu_data = bus.alu_data + 1;
                end
            end
            chk("starve_written", {31'd0, seen_at > 0 && seen_at <= LIMIT + 2}, 32'd1);
            chk("starve_stall_count", stalls, 1);
        end

        // Reset with a full buffer and pending bits
        idle(); bus.alu_valid = 1; bus.alu_num = 10; bus.alu_data = 32'h5;
        bus.lsu_valid = 1; bus.lsu_num = 20; bus.lsu_data = 32'h20;
        bus.issue_valid = 1; bus.issue_num = 20;
        step();
        bus.lsu_num = 21; bus.lsu_data = 32'h21; bus.issue_num = 21;
        step();
        idle(); bus.rd1 = 20; bus.rd2 = 21;
        #1 chk("mid_busy1", {31'd0, bus.busy1}, 32'd1);
        chk("mid_busy2", {31'd0, bus.busy2}, 32'd1);
        chk("mid_full", {31'd0, bus.lsu_ready}, 32'd0);
        rst = 1;
        step();
        chk("mrst_reg_wr", {31'd0, bus.reg_wr}, 32'd0);
        chk("mrst_busy1", {31'd0, bus.busy1}, 32'd0);
        chk("mrst_ready", {31'd0, bus.lsu_ready}, 32'd0);
        rst = 0;
        #1 chk("mrst_ready_after", {31'd0, bus.lsu_ready}, 32'd1);
        chk("mrst_busy1_after", {31'd0, bus.busy1}, 32'd0);
        chk("mrst_busy2_after", {31'd0, bus.busy2}, 32'd0);
        step();
        chk("mrst_no_pop", {31'd0, bus.reg_wr}, 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if (!last_stall || rst) begin
                bus.alu_valid = ($urandom_range(0, 2) != 0);
                bus.alu_num   = 5'($urandom);
                bus.alu_data  = $urandom;
            end
            rst = ($urandom_range(0, 299) == 0);
            bus.lsu_valid   = $urandom_range(0, 1);
            bus.lsu_num     = 5'($urandom);
            bus.lsu_data    = $urandom;
            bus.issue_valid = 0;
            bus.issue_num   = 0;
            if ($urandom_range(0, 2) == 0) begin
                logic [4:0] r = 5'($urandom);
                if (!m_pend[r]) begin
                    bus.issue_valid = 1;
                    bus.issue_num   = r;
                end
            end
            bus.rd1 = 5'($urandom);
            bus.rd2 = 5'($urandom);
            step();
        end
        rst = 0;
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
